// File: rtl/mmio_periph_map_pkg.sv
// Register map, STATUS bit positions and the address-window decoder shared
// by the MMIO peripheral block.
`timescale 1ns/1ps
package mmio_periph_pkg;

    localparam logic [31:0] STATUS_OFF   = 32'h00;
    localparam logic [31:0] BTN_OFF      = 32'h04;
    localparam logic [31:0] SW_DATA_OFF  = 32'h08;
    localparam logic [31:0] SEG_OFF      = 32'h0C;
    localparam logic [31:0] LED_BASE_OFF = 32'h10;

    localparam int unsigned ST_BTN_PEND   = 0;
    localparam int unsigned ST_FIFO_EMPTY = 1;
    localparam int unsigned ST_FIFO_FULL  = 2;
    localparam int unsigned ST_SEG_BUSY   = 3;
    localparam int unsigned ST_SEG_OVF    = 4;
    localparam int unsigned ST_SW_OVF     = 5;
    localparam int unsigned ST_CNT_LSB    = 8;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_STATUS,
        REG_BTN,
        REG_SW,
        REG_SEG,
        REG_LED
    } reg_sel_e;

    // off is the byte offset from the window base; addresses below the base
    // wrap to huge offsets and therefore never match.
    function automatic reg_sel_e decode_reg(input logic [31:0] off, input int unsigned n_led);
        reg_sel_e sel;
        sel = REG_NONE;
        if (off[1:0] == 2'b00) begin
            if (off == STATUS_OFF)
                sel = REG_STATUS;
            else if (off == BTN_OFF)
                sel = REG_BTN;
            else if (off == SW_DATA_OFF)
                sel = REG_SW;
            else if (off == SEG_OFF)
                sel = REG_SEG;
            else if (off >= LED_BASE_OFF && off < LED_BASE_OFF + 32'(4 * n_led))
                sel = REG_LED;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mmio_periph_map_if.sv
// CPU data-memory port as seen by the MMIO peripheral block.
`timescale 1ns/1ps
interface mmio_periph_map_if;
    logic [31:0] mmio_addr;
    logic        mmio_we;
    logic        mmio_re;
    logic [31:0] mmio_din;
    logic [31:0] mmio_dout;

    modport master (output mmio_addr, output mmio_we, output mmio_re, output mmio_din,
                    input  mmio_dout);
    modport slave  (input  mmio_addr, input  mmio_we, input  mmio_re, input  mmio_din,
                    output mmio_dout);
endinterface

// File: rtl/mmio_periph_map_sync_fifo.sv
// Synchronous FIFO with first-word fall-through head; head reads 0 when empty.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop_ok);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok)
                count <= count + CW'(1);
            else if (pop_ok && !push_ok)
                count <= count - CW'(1);
        end
    end
endmodule

// File: rtl/mmio_periph_map.sv
// MMIO peripheral window: button press capture into a switch FIFO, press
// counter, 7-seg valid/ready output register and an LED register bank.
`timescale 1ns/1ps
module mmio_periph_map
    import mmio_periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_7f00,
    parameter int unsigned N_LED         = 4,
    parameter int unsigned SW_FIFO_DEPTH = 4,
    parameter int unsigned BTN_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mmio_periph_map_if.slave     bus,
    input  logic                 btn,
    input  logic [31:0]          shift_reg_data,
    output logic [31:0]          pc_seg_data,
    output logic                 pc_seg_vld,
    input  logic                 pc_seg_rdy,
    output logic [N_LED-1:0]     led_out
);
    localparam int unsigned FCNT_W = $clog2(SW_FIFO_DEPTH) + 1;

    logic [31:0]          off;
    reg_sel_e             sel;
    logic [31:0]          led_idx;
    logic                 wr_status, wr_btn, wr_seg, wr_led, rd_sw;

    logic                 btn_q, btn_ev, btn_pend;
    logic [BTN_CNT_W-1:0] btn_cnt;
    logic                 sw_ovf, seg_ovf, seg_busy;

    logic [31:0]          fifo_head;
    logic                 fifo_full, fifo_empty, pop_ok;
    logic [FCNT_W-1:0]    fifo_count;

    logic [31:0]          led_reg [N_LED];
    logic [31:0]          rdata;

    assign off       = bus.mmio_addr - BASE_ADDR;
    assign sel       = decode_reg(off, N_LED);
    assign led_idx   = (off - LED_BASE_OFF) >> 2;
    assign wr_status = bus.mmio_we && (sel == REG_STATUS);
    assign wr_btn    = bus.mmio_we && (sel == REG_BTN);
    assign wr_seg    = bus.mmio_we && (sel == REG_SEG);
    assign wr_led    = bus.mmio_we && (sel == REG_LED);
    assign rd_sw     = bus.mmio_re && (sel == REG_SW);

    assign btn_ev    = btn && !btn_q;
    assign pop_ok    = rd_sw && !fifo_empty;
    assign seg_busy  = pc_seg_vld && !pc_seg_rdy;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (SW_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (btn_ev),
        .pop   (pop_ok),
        .din   (shift_reg_data),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A press coinciding with a BTN write survives as pending=1, count=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q    <= 1'b0;
            btn_pend <= 1'b0;
            btn_cnt  <= '0;
        end else begin
            btn_q <= btn;
            if (wr_btn) begin
                btn_pend <= btn_ev;
                btn_cnt  <= btn_ev ? BTN_CNT_W'(1) : '0;
            end else if (btn_ev) begin
                btn_pend <= 1'b1;
                if (btn_cnt != '1)
                    btn_cnt <= btn_cnt + BTN_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_ovf  <= 1'b0;
            seg_ovf <= 1'b0;
        end else begin
            if (btn_ev && fifo_full && !pop_ok)
                sw_ovf <= 1'b1;
            else if (wr_status && bus.mmio_din[ST_SW_OVF])
                sw_ovf <= 1'b0;
            if (wr_seg && seg_busy)
                seg_ovf <= 1'b1;
            else if (wr_status && bus.mmio_din[ST_SEG_OVF])
                seg_ovf <= 1'b0;
        end
    end

    // A write during the accepting cycle reloads the word, so vld stays high.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_seg_vld  <= 1'b0;
            pc_seg_data <= '0;
        end else if (wr_seg && !seg_busy) begin
            pc_seg_vld  <= 1'b1;
            pc_seg_data <= bus.mmio_din;
        end else if (pc_seg_vld && pc_seg_rdy) begin
            pc_seg_vld  <= 1'b0;
        end
    end

    for (genvar i = 0; i < N_LED; i++) begin : g_led
        always_ff @(posedge clk) begin
            if (rst)
                led_reg[i] <= '0;
            else if (wr_led && led_idx == 32'(i))
                led_reg[i] <= bus.mmio_din;
        end
        assign led_out[i] = led_reg[i][0];
    end

    always_comb begin
        rdata = '0;
        case (sel)
            REG_STATUS: begin
                rdata[ST_BTN_PEND]        = btn_pend;
                rdata[ST_FIFO_EMPTY]      = fifo_empty;
                rdata[ST_FIFO_FULL]       = fifo_full;
                rdata[ST_SEG_BUSY]        = seg_busy;
                rdata[ST_SEG_OVF]         = seg_ovf;
                rdata[ST_SW_OVF]          = sw_ovf;
                rdata[ST_CNT_LSB +: 8]    = 8'(fifo_count);
            end
            REG_BTN: begin
                rdata[0]                  = btn_pend;
                rdata[8 +: BTN_CNT_W]     = btn_cnt;
            end
            REG_SW:  rdata = fifo_head;
            REG_SEG: rdata = pc_seg_data;
            REG_LED: begin
                for (int unsigned i = 0; i < N_LED; i++)
                    if (led_idx == i)
                        rdata = led_reg[i];
            end
            default: rdata = '0;
        endcase
    end

    assign bus.mmio_dout = rdata;
endmodule
